// File: rtl/out_buf_pp.sv
// NBANK ping-pong output buffer: PPU fills one bank while a committed bank drains over valid/ready.
// Commit->first o_rd_valid is 2 cycles; 1 word/cycle across banks; outputs hold while i_rd_ready is low.
module out_buf_pp #(
    parameter  int LANES = 16,
    parameter  int DW    = 4,
    parameter  int DEPTH = 64,
    parameter  int NBANK = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int BW    = (NBANK > 2) ? $clog2(NBANK) : 1,
    localparam int FW    = $clog2(NBANK + 1),
    localparam int WW    = LANES * DW
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WW-1:0]    i_wr_data,
    input  logic [LANES-1:0] i_wr_mask,
    input  logic             i_commit,
    input  logic [CW-1:0]    i_commit_cnt,
    output logic             o_wr_ready,
    output logic             o_wr_err,
    output logic             o_rd_valid,
    output logic [WW-1:0]    o_rd_data,
    output logic [AW-1:0]    o_rd_addr,
    output logic [BW-1:0]    o_rd_bank,
    output logic             o_rd_last,
    input  logic             i_rd_ready,
    output logic [FW-1:0]    o_full_cnt,
    output logic             o_bank_done
);
    localparam int MW = $clog2(NBANK * DEPTH);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_e;
    typedef enum logic {D_IDLE, D_STREAM} drain_st_e;

    bank_st_e      st_q  [NBANK];
    logic [CW-1:0] len_q [NBANK];
    logic [WW-1:0] mem   [NBANK*DEPTH];

    logic [BW-1:0] wb_q, rb_q;
    logic [CW-1:0] ra_q;
    drain_st_e     dst_q;
    logic          wr_err_q, rd_valid_q, rd_last_q, bank_done_q;
    logic [WW-1:0] rd_data_q;
    logic [AW-1:0] rd_addr_q;
    logic [BW-1:0] rd_bank_q;
    logic [FW-1:0] full_cnt_q;

    logic          wr_rdy, cnt_ok, wr_fire, cm_try, cm_fire;
    logic          acc, last_acc, avail, issue;
    logic [BW-1:0] rb_nx, sel;
    logic [CW-1:0] ptr;
    logic [MW-1:0] widx, ridx;

    function automatic logic [BW-1:0] bnext(input logic [BW-1:0] b);
        return (b == BW'(NBANK - 1)) ? '0 : b + 1'b1;
    endfunction

    function automatic logic [MW-1:0] midx(input logic [BW-1:0] b, input logic [CW-1:0] a);
        return MW'(b) * MW'(DEPTH) + MW'(a);
    endfunction

    always_comb begin
        wr_rdy   = (st_q[wb_q] == B_EMPTY) || (st_q[wb_q] == B_FILLING);
        cnt_ok   = (i_commit_cnt != '0) && (i_commit_cnt <= CW'(DEPTH));
        wr_fire  = i_wr_en && wr_rdy;
        cm_try   = i_commit && wr_rdy;
        cm_fire  = cm_try && cnt_ok;
        acc      = rd_valid_q && i_rd_ready;
        last_acc = acc && rd_last_q;
        rb_nx    = bnext(rb_q);
        // On last-word acceptance, look ahead to the next bank so streams chain without a bubble.
        if (last_acc) begin
            sel   = rb_nx;
            ptr   = '0;
            avail = (st_q[rb_nx] == B_FULL);
        end else begin
            sel   = rb_q;
            ptr   = ra_q;
            avail = (dst_q == D_STREAM) && (ra_q < len_q[rb_q]);
        end
        issue = avail && (!rd_valid_q || i_rd_ready);
        widx  = midx(wb_q, CW'(i_wr_addr));
        ridx  = midx(sel, ptr);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < NBANK; b++) begin
                st_q[b]  <= B_EMPTY;
                len_q[b] <= '0;
            end
            wb_q        <= '0;
            rb_q        <= '0;
            ra_q        <= '0;
            dst_q       <= D_IDLE;
            wr_err_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_bank_q   <= '0;
            rd_last_q   <= 1'b0;
            full_cnt_q  <= '0;
            bank_done_q <= 1'b0;
        end else begin
            bank_done_q <= last_acc;
            if (((i_wr_en || i_commit) && !wr_rdy) || (cm_try && !cnt_ok)) begin
                wr_err_q <= 1'b1;
            end

            if (last_acc) begin
                st_q[rb_q] <= B_EMPTY;
                rb_q       <= rb_nx;
                ra_q       <= '0;
            end
            if (issue) begin
                st_q[sel]  <= B_DRAINING;
                rd_valid_q <= 1'b1;
                rd_addr_q  <= AW'(ptr);
                rd_bank_q  <= sel;
                rd_last_q  <= (ptr == len_q[sel] - 1'b1);
                ra_q       <= ptr + 1'b1;
            end else if (acc) begin
                rd_valid_q <= 1'b0;
            end

            case (dst_q)
                D_IDLE:   if (st_q[rb_q] == B_FULL) dst_q <= D_STREAM;
                D_STREAM: if (last_acc && st_q[rb_nx] != B_FULL) dst_q <= D_IDLE;
                default:  dst_q <= D_IDLE;
            endcase

            // The fill bank is never the one being drained, so these indices never collide.
            if ((wr_fire || cm_try) && st_q[wb_q] == B_EMPTY) begin
                st_q[wb_q] <= B_FILLING;
            end
            if (cm_fire) begin
                st_q[wb_q]  <= B_FULL;
                len_q[wb_q] <= i_commit_cnt;
                wb_q        <= bnext(wb_q);
            end

            case ({cm_fire, last_acc})
                2'b10:   full_cnt_q <= full_cnt_q + 1'b1;
                2'b01:   full_cnt_q <= full_cnt_q - 1'b1;
                default: full_cnt_q <= full_cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_fire) begin
            for (int l = 0; l < LANES; l++) begin
                if (i_wr_mask[l]) mem[widx][l*DW +: DW] <= i_wr_data[l*DW +: DW];
            end
        end
    end

    // Output register of the synchronous read port; the array itself is never reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_data_q <= '0;
        end else if (issue) begin
            rd_data_q <= mem[ridx];
        end
    end

    assign o_wr_ready  = wr_rdy;
    assign o_wr_err    = wr_err_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_data   = rd_data_q;
    assign o_rd_addr   = rd_addr_q;
    assign o_rd_bank   = rd_bank_q;
    assign o_rd_last   = rd_last_q;
    assign o_full_cnt  = full_cnt_q;
    assign o_bank_done = bank_done_q;

endmodule

// File: tb/tb_out_buf_pp.sv
// Directed bench for out_buf_pp with default parameters (16 lanes x 4 bits, 64 words, 2 banks).
module tb_out_buf_pp;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [63:0] wr_data;
    logic [15:0] wr_mask;
    logic        commit;
    logic [6:0]  commit_cnt;
    logic        wr_ready, wr_err, rd_valid, rd_last, rd_ready, bank_done;
    logic [63:0] rd_data;
    logic [5:0]  rd_addr;
    logic        rd_bank;
    logic [1:0]  full_cnt;

    int n_chk = 0;
    int n_err = 0;

    out_buf_pp dut (
        .i_clk(clk), .i_rst(rst),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_mask(wr_mask),
        .i_commit(commit), .i_commit_cnt(commit_cnt),
        .o_wr_ready(wr_ready), .o_wr_err(wr_err),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_addr(rd_addr),
        .o_rd_bank(rd_bank), .o_rd_last(rd_last), .i_rd_ready(rd_ready),
        .o_full_cnt(full_cnt), .o_bank_done(bank_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mkw(input int tag, input int a);
        return {4{tag[7:0], a[7:0]}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; wr_en = 1'b0; commit = 1'b0; rd_ready = 1'b0;
        wr_addr = '0; wr_data = '0; wr_mask = '0; commit_cnt = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic check_reset;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_bank", rd_bank, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_full_cnt", full_cnt, 0);
        chk("rst_bank_done", bank_done, 0);
    endtask

    task automatic wr(input int a, input logic [63:0] d, input logic [15:0] m);
        wr_en = 1'b1; wr_addr = a[5:0]; wr_data = d; wr_mask = m;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic do_commit(input int cnt);
        commit = 1'b1; commit_cnt = cnt[6:0];
        tick;
        commit = 1'b0;
    endtask

    // Accepts n words of a bank of length len; while ready is low the held word must already be the expected one.
    task automatic drain(input int bank, input int tag, input int n, input int len, input bit bp,
                         input bit imm, input int sp_addr, input logic [63:0] sp_word);
        int got = 0;
        int cyc = 0;
        logic [63:0] exp;
        if (imm) chk("no_bubble", rd_valid, 1);
        while (got < n && cyc < 400) begin
            rd_ready = bp ? (cyc % 3 == 0) : 1'b1;
            exp = (got == sp_addr) ? sp_word : mkw(tag, got);
            if (rd_valid) begin
                if (rd_ready) begin
                    chk("rd_data", rd_data, exp);
                    chk("rd_addr", rd_addr, got);
                    chk("rd_bank", rd_bank, bank);
                    chk("rd_last", rd_last, got == len - 1);
                    got++;
                end else begin
                    chk("rd_hold", rd_data, exp);
                end
            end
            tick;
            cyc++;
        end
        chk("drain_cnt", got, n);
        if (n == len) chk("bank_done", bank_done, 1);
    endtask

    task automatic single_bank(input int tag);
        rd_ready = 1'b1;
        for (int a = 0; a < 64; a++) wr(a, mkw(tag, a), '1);
        do_commit(64);
        chk("sb_full1", full_cnt, 1);
        chk("sb_valid_k", rd_valid, 0);
        tick;
        chk("sb_valid_k1", rd_valid, 0);
        tick;
        chk("sb_valid_k2", rd_valid, 1);
        drain(0, tag, 64, 64, 0, 1, -1, '0);
        chk("sb_full0", full_cnt, 0);
        chk("sb_valid_end", rd_valid, 0);
        tick;
        chk("sb_done_pulse", bank_done, 0);
    endtask

    initial begin
        do_reset;
        check_reset;

        single_bank(1);

        // Ping-pong: bank 1 is filled and committed while bank 0 streams.
        do_reset;
        for (int a = 0; a < 64; a++) wr(a, mkw(2, a), '1);
        do_commit(64);
        fork
            begin
                for (int a = 0; a < 48; a++) wr(a, mkw(3, a), '1);
                do_commit(48);
            end
            begin
                drain(0, 2, 64, 64, 0, 0, -1, '0);
                drain(1, 3, 48, 48, 0, 1, -1, '0);
            end
        join
        chk("pp_full0", full_cnt, 0);

        // Back-pressure on a 16-word bank.
        do_reset;
        for (int a = 0; a < 16; a++) wr(a, mkw(4, a), '1);
        do_commit(16);
        drain(0, 4, 16, 16, 1, 0, -1, '0);
        rd_ready = 1'b1;
        tick;
        tick;
        chk("bp_no_extra", rd_valid, 0);

        // Overrun: both banks committed with the consumer stalled.
        do_reset;
        for (int a = 0; a < 4; a++) wr(a, mkw(5, a), '1);
        do_commit(4);
        for (int a = 0; a < 4; a++) wr(a, mkw(6, a), '1);
        do_commit(4);
        chk("ov_ready0", wr_ready, 0);
        chk("ov_full2", full_cnt, 2);
        chk("ov_err0", wr_err, 0);
        wr(0, 64'hDEAD_BEEF_DEAD_BEEF, '1);
        do_commit(4);
        chk("ov_err1", wr_err, 1);
        chk("ov_full2b", full_cnt, 2);
        drain(0, 5, 4, 4, 0, 1, -1, '0);
        chk("ov_ready1", wr_ready, 1);
        drain(1, 6, 4, 4, 0, 1, -1, '0);
        chk("ov_full0", full_cnt, 0);
        chk("ov_err_sticky", wr_err, 1);

        // Lane mask and partial length, then a zero-length commit.
        do_reset;
        rd_ready = 1'b1;
        wr(5, 64'hFFFF_FFFF_FFFF_FFFF, '1);
        wr(5, 64'h0, 16'h00FF);
        for (int a = 0; a < 5; a++) wr(a, mkw(7, a), '1);
        do_commit(6);
        drain(0, 7, 6, 6, 0, 0, 5, 64'hFFFF_FFFF_0000_0000);
        chk("mk_err0", wr_err, 0);
        do_commit(0);
        chk("mk_err1", wr_err, 1);
        chk("mk_full0", full_cnt, 0);
        chk("mk_ready", wr_ready, 1);
        tick;
        tick;
        tick;
        chk("mk_no_drain", rd_valid, 0);

        // Reset in the middle of a drain, then a fresh single-bank run.
        do_reset;
        rd_ready = 1'b1;
        for (int a = 0; a < 64; a++) wr(a, mkw(8, a), '1);
        do_commit(64);
        drain(0, 8, 10, 64, 0, 0, -1, '0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        rd_ready = 1'b0;
        check_reset;
        single_bank(9);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
